// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EXE and WB.
// Holds one instruction. A load's synchronous SRAM data is live only in the
// first cycle after the instruction latches. If the instruction stalls, that
// data is captured into rdata_buf, so the result stays stable while it waits.
// Optional feature: define MS_FWD_EN to add the ms_fwd_data bypass port.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        es_to_ms_valid,
    input  logic [70:0] es_to_ms_bus,
    output logic        ms_allowin,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    input  logic [31:0] data_sram_rdata,
    output logic [5:0]  ms_dest_withvalid
`ifdef MS_FWD_EN
    ,
    output logic [31:0] ms_fwd_data
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LIVE  = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        ms_valid;
    logic [70:0] ms_bus_r;
    logic [31:0] rdata_buf;

    logic        ms_ready_go;
    logic        enter;
    logic        leave;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [31:0] final_result;
    logic        block_valid;

    assign res_from_mem = ms_bus_r[70];
    assign gr_we        = ms_bus_r[69];
    assign dest         = ms_bus_r[68:64];
    assign alu_result   = ms_bus_r[63:32];
    assign pc           = ms_bus_r[31:0];

    // Handshake: this stage always finishes in one cycle.
    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign enter          = es_to_ms_valid && ms_allowin;
    assign leave          = ms_valid && ms_ready_go && ws_allowin;

    // Pipeline register: valid follows the handshake, payload loads only on a real transfer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
            ms_bus_r <= '0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (enter) begin
                ms_bus_r <= es_to_ms_bus;
            end
        end
    end

    // Read-capture FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a new instruction always wins, so stale buffered data is never selected for it.
    always_comb begin
        state_next = state;
        if (enter) begin
            state_next = LIVE;
        end else if (leave) begin
            state_next = EMPTY;
        end else if (state == LIVE) begin
            state_next = HELD;
        end
    end

    // Capture load data on the edge where a first-cycle load stalls instead of leaving.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_buf <= '0;
        end else if (state == LIVE && state_next == HELD && res_from_mem) begin
            rdata_buf <= data_sram_rdata;
        end
    end

    // Result select: live SRAM data in the first cycle, buffered copy afterwards.
    always_comb begin
        final_result = alu_result;
        if (res_from_mem) begin
            final_result = (state == LIVE) ? data_sram_rdata : rdata_buf;
        end
    end

    assign block_valid       = ms_valid && gr_we && (dest != 5'd0);
    assign ms_dest_withvalid = {block_valid, dest};
    assign ms_to_ws_bus      = {gr_we, dest, final_result, pc};

`ifdef MS_FWD_EN
    assign ms_fwd_data = final_result;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus randomized traffic for mem_stage,
// checked against a transaction-level model of the stage.
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        es_to_ms_valid;
    logic [70:0] es_to_ms_bus;
    logic        ms_allowin;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [31:0] data_sram_rdata;
    logic [5:0]  ms_dest_withvalid;
`ifdef MS_FWD_EN
    logic [31:0] ms_fwd_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the instruction held by the stage, how many cycles it has been
    // there, and the load word it saw in its first cycle.
    logic        m_valid;
    logic [70:0] m_instr;
    int          m_age;
    logic [31:0] m_load_word;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_rdata   (data_sram_rdata),
        .ms_dest_withvalid (ms_dest_withvalid)
`ifdef MS_FWD_EN
        ,
        .ms_fwd_data       (ms_fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [70:0] mk(input logic ld, input logic we, input logic [4:0] d,
                                       input logic [31:0] alu, input logic [31:0] pc);
        return {ld, we, d, alu, pc};
    endfunction

    function automatic logic [31:0] model_result(input logic [31:0] rd);
        if (!m_instr[70]) return m_instr[63:32];
        if (m_age == 0) return rd;
        return m_load_word;
    endfunction

    task automatic model_reset();
        m_valid     = 1'b0;
        m_instr     = '0;
        m_age       = 0;
        m_load_word = '0;
    endtask

    // Drive inputs after the falling edge, then compare every output with the model.
    task automatic settle(input logic ev, input logic [70:0] eb, input logic ws, input logic [31:0] rd);
        logic        m_block;
        logic [31:0] m_res;
        @(negedge clk);
        es_to_ms_valid  = ev;
        es_to_ms_bus    = eb;
        ws_allowin      = ws;
        data_sram_rdata = rd;
        #1;
        m_block = m_valid && m_instr[69] && (m_instr[68:64] != 5'd0);
        m_res   = model_result(rd);
        check("ms_to_ws_valid", 70'(ms_to_ws_valid), 70'(m_valid));
        check("ms_allowin", 70'(ms_allowin), 70'(!m_valid || ws));
        check("ms_dest_withvalid", 70'(ms_dest_withvalid), 70'({m_block, m_instr[68:64]}));
        if (m_valid) begin
            check("ms_to_ws_bus", ms_to_ws_bus, {m_instr[69:64], m_res, m_instr[31:0]});
        end
`ifdef MS_FWD_EN
        if (m_block) begin
            check("ms_fwd_data", 70'(ms_fwd_data), 70'(m_res));
        end
`endif
    endtask

    // Rising edge: advance the model with the inputs that were held across it.
    task automatic commit();
        logic accept;
        @(posedge clk);
        accept = !m_valid || ws_allowin;
        if (accept && es_to_ms_valid) begin
            m_valid = 1'b1;
            m_instr = es_to_ms_bus;
            m_age   = 0;
        end else if (accept) begin
            m_valid = 1'b0;
        end else begin
            if (m_age == 0) m_load_word = data_sram_rdata;
            m_age++;
        end
    endtask

    task automatic cycle(input logic ev, input logic [70:0] eb, input logic ws, input logic [31:0] rd);
        settle(ev, eb, ws, rd);
        commit();
    endtask

    initial begin
        resetn          = 1'b0;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        ws_allowin      = 1'b0;
        data_sram_rdata = '0;
        model_reset();

        // Reset state
        #12;
        check("rst_valid", 70'(ms_to_ws_valid), 70'(0));
        check("rst_allowin", 70'(ms_allowin), 70'(1));
        check("rst_dest", 70'(ms_dest_withvalid), 70'(0));
        check("rst_bus", ms_to_ws_bus, 70'(0));
        @(negedge clk);
        resetn = 1'b1;

        // ALU op passes straight through
        cycle(1'b1, mk(1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h100), 1'b1, 32'hFFFF_FFFF);
        settle(1'b0, '0, 1'b1, 32'h5555_5555);
        check("alu_result", 70'(ms_to_ws_bus[63:32]), 70'(32'h1234));
        check("alu_dest", 70'(ms_dest_withvalid), 70'(6'h25));
        commit();

        // Load stalls three cycles while SRAM data goes away
        cycle(1'b1, mk(1'b1, 1'b1, 5'd7, 32'h0, 32'h200), 1'b1, 32'h0);
        settle(1'b0, '0, 1'b0, 32'hDEAD_BEEF);
        check("load_live", 70'(ms_to_ws_bus[63:32]), 70'(32'hDEAD_BEEF));
        commit();
        for (int i = 0; i < 3; i++) begin
            settle(1'b0, '0, 1'b0, 32'h0);
            check("load_held", 70'(ms_to_ws_bus[63:32]), 70'(32'hDEAD_BEEF));
            check("held_allowin", 70'(ms_allowin), 70'(0));
            commit();
        end
        cycle(1'b0, '0, 1'b1, 32'h0);

        // Back-to-back loads without a bubble
        cycle(1'b1, mk(1'b1, 1'b1, 5'd3, 32'h0, 32'h300), 1'b1, 32'h0);
        settle(1'b1, mk(1'b1, 1'b1, 5'd4, 32'h0, 32'h304), 1'b1, 32'h11);
        check("b2b_first", 70'(ms_to_ws_bus[63:32]), 70'(32'h11));
        commit();
        settle(1'b0, '0, 1'b1, 32'h22);
        check("b2b_second", 70'(ms_to_ws_bus[63:32]), 70'(32'h22));
        check("b2b_pc", 70'(ms_to_ws_bus[31:0]), 70'(32'h304));
        check("b2b_valid", 70'(ms_to_ws_valid), 70'(1));
        commit();

        // Writes to r0 never block decode
        cycle(1'b1, mk(1'b0, 1'b1, 5'd0, 32'h77, 32'h400), 1'b1, 32'h0);
        settle(1'b0, '0, 1'b1, 32'h0);
        check("dest0", 70'(ms_dest_withvalid), 70'(6'h00));
        commit();

`ifdef MS_FWD_EN
        // Forwarded value stays stable through a load stall
        cycle(1'b1, mk(1'b1, 1'b1, 5'd9, 32'h0, 32'h500), 1'b1, 32'h0);
        cycle(1'b0, '0, 1'b0, 32'hCAFE_0001);
        for (int i = 0; i < 3; i++) begin
            settle(1'b0, '0, 1'b0, 32'h1234_5678);
            check("fwd_held", 70'(ms_fwd_data), 70'(32'hCAFE_0001));
            commit();
        end
        cycle(1'b0, '0, 1'b1, 32'h0);
`endif

        // Asynchronous reset while a load is held
        cycle(1'b1, mk(1'b1, 1'b1, 5'd6, 32'h0, 32'h600), 1'b1, 32'h0);
        cycle(1'b0, '0, 1'b0, 32'hABCD_0000);
        settle(1'b0, '0, 1'b0, 32'h0);
        resetn = 1'b0;
        #1;
        check("arst_valid", 70'(ms_to_ws_valid), 70'(0));
        check("arst_allowin", 70'(ms_allowin), 70'(1));
        check("arst_dest", 70'(ms_dest_withvalid), 70'(0));
        check("arst_bus", ms_to_ws_bus, 70'(0));
        model_reset();
        @(negedge clk);
        resetn = 1'b1;

        // First edge after reset release accepts an instruction
        cycle(1'b1, mk(1'b0, 1'b1, 5'd2, 32'hBEEF, 32'h700), 1'b0, 32'h0);
        settle(1'b0, '0, 1'b1, 32'h0);
        check("post_rst_valid", 70'(ms_to_ws_valid), 70'(1));
        check("post_rst_pc", 70'(ms_to_ws_bus[31:0]), 70'(32'h700));
        commit();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic        ev;
            logic        ws;
            logic [70:0] eb;
            ev = ($urandom_range(0, 9) < 7);
            ws = ($urandom_range(0, 9) < 6);
            eb = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom};
            cycle(ev, eb, ws, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
